// File: rtl/slide_scan_seq.sv
// slide_scan_seq: round-robin scanner for the slide-potentiometer bank.
// It steps through NUM_CH logical slots. Each slot maps to a physical A2D
// channel through CH_MAP. The block runs the strt_cnv / cnv_cmplt / res
// handshake for every slot and keeps the latest result per slot. It also
// drives per-slot update strobes, a scan-complete pulse and a sticky
// timeout flag.
// Optional feature: define SLIDE_AVG_EN to replace the direct result load
// with a first-order IIR average. The shift is AVG_SHFT, and the first
// capture per slot after reset loads the raw result.
module slide_scan_seq #(
  parameter int                  NUM_CH      = 6,
  parameter int                  RES_W       = 12,
  parameter logic [3*NUM_CH-1:0] CH_MAP      = {3'd7, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
  parameter int                  SETTLE_CYC  = 16,
  parameter int                  TIMEOUT_CYC = 4096,
  parameter int                  AVG_SHFT    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    cnv_cmplt,
  input  logic [RES_W-1:0]        res,
  output logic [2:0]              chnnl,
  output logic                    strt_cnv,
  output logic [NUM_CH*RES_W-1:0] pot_vals,
  output logic [NUM_CH-1:0]       upd,
  output logic                    scan_done,
  output logic                    timeout
);

  localparam int SLOT_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMR_W       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int SETTLE_LAST = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
  localparam int SET_W       = (SETTLE_LAST > 0) ? $clog2(SETTLE_LAST + 1) : 1;

  // Reject configurations the counters and slot indexing cannot represent.
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_chk_num_ch
    $error("slide_scan_seq: NUM_CH must be in 1..8");
  end
  if (TIMEOUT_CYC < 2) begin : g_chk_timeout
    $error("slide_scan_seq: TIMEOUT_CYC must be at least 2");
  end
  if (AVG_SHFT < 0 || AVG_SHFT >= RES_W) begin : g_chk_shft
    $error("slide_scan_seq: AVG_SHFT must be in 0..RES_W-1");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT, SETTLE} state_t;

  state_t            state;
  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] slot_nxt;
  logic              last_slot;
  logic [TMR_W-1:0]  timer;
  logic [SET_W-1:0]  settle_cnt;
  logic [RES_W-1:0]  cap_val;

  // Next-slot selection with wrap at the last slot.
  always_comb begin
    last_slot = (slot == SLOT_W'(NUM_CH - 1));
    slot_nxt  = last_slot ? '0 : slot + 1'b1;
  end

`ifdef SLIDE_AVG_EN
  logic [NUM_CH-1:0]     primed;
  logic signed [RES_W:0] cur_s;
  logic signed [RES_W:0] diff_s;
  logic signed [RES_W:0] avg_s;

  // IIR step in signed RES_W+1 arithmetic; the first capture of a slot loads res.
  always_comb begin
    cur_s  = $signed({1'b0, pot_vals[RES_W*slot +: RES_W]});
    diff_s = $signed({1'b0, res}) - cur_s;
    avg_s  = cur_s + (diff_s >>> AVG_SHFT);
    if (!primed[slot])
      cap_val = res;
    else if (avg_s[RES_W])
      cap_val = '0;
    else
      cap_val = avg_s[RES_W-1:0];
  end
`else
  // Direct load of the conversion result.
  always_comb cap_val = res;
`endif

  // Scan FSM with registered handshake, result and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      slot       <= '0;
      chnnl      <= CH_MAP[2:0];
      strt_cnv   <= 1'b0;
      pot_vals   <= '0;
      upd        <= '0;
      scan_done  <= 1'b0;
      timeout    <= 1'b0;
      timer      <= '0;
      settle_cnt <= '0;
`ifdef SLIDE_AVG_EN
      primed     <= '0;
`endif
    end else begin
      strt_cnv  <= 1'b0;
      upd       <= '0;
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state    <= START;
            strt_cnv <= 1'b1;
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // timer==0 is the first WAIT cycle, where a stale cnv_cmplt is ignored
          if (timer != '0 && cnv_cmplt) begin
            pot_vals[RES_W*slot +: RES_W] <= cap_val;
            upd        <= NUM_CH'(1) << slot;
            scan_done  <= last_slot;
            settle_cnt <= '0;
            state      <= SETTLE;
`ifdef SLIDE_AVG_EN
            primed[slot] <= 1'b1;
`endif
          end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
            timeout    <= 1'b1;
            scan_done  <= last_slot;
            settle_cnt <= '0;
            state      <= SETTLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == SET_W'(SETTLE_LAST)) begin
            slot  <= slot_nxt;
            chnnl <= CH_MAP[3*slot_nxt +: 3];
            if (last_slot && !en) begin
              state <= IDLE;
            end else begin
              state    <= START;
              strt_cnv <= 1'b1;
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slide_scan_seq.sv
// tb_slide_scan_seq: randomized bench for slide_scan_seq with default
// parameters. It includes an A2D responder and a slot-level reference model
// of the expected results.
module tb_slide_scan_seq;

  localparam int          NUM_CH      = 6;
  localparam int          RES_W       = 12;
  localparam int          SETTLE_CYC  = 16;
  localparam int          TIMEOUT_CYC = 4096;
  localparam int          AVG_SHFT    = 2;
  localparam logic [17:0] CH_MAP      = {3'd7, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    en;
  logic                    cnv_cmplt;
  logic [RES_W-1:0]        res;
  logic [2:0]              chnnl;
  logic                    strt_cnv;
  logic [NUM_CH*RES_W-1:0] pot_vals;
  logic [NUM_CH-1:0]       upd;
  logic                    scan_done;
  logic                    timeout;

  int n_cmp = 0;
  int n_bad = 0;

  int exp_pot[NUM_CH];
  bit exp_primed[NUM_CH];
  int exp_slot;

  always #5 clk = ~clk;

  slide_scan_seq #(
    .NUM_CH(NUM_CH), .RES_W(RES_W), .CH_MAP(CH_MAP),
    .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .AVG_SHFT(AVG_SHFT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cnv_cmplt(cnv_cmplt), .res(res),
    .chnnl(chnnl), .strt_cnv(strt_cnv), .pot_vals(pot_vals), .upd(upd),
    .scan_done(scan_done), .timeout(timeout)
  );

  function automatic logic [2:0] ch_of(input int s);
    return CH_MAP[3*s +: 3];
  endfunction

  function automatic logic [NUM_CH*RES_W-1:0] exp_vec();
    logic [NUM_CH*RES_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) v[RES_W*i +: RES_W] = exp_pot[i][RES_W-1:0];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      exp_pot[i]    = 0;
      exp_primed[i] = 1'b0;
    end
    exp_slot = 0;
  endtask

  task automatic model_capture(input int v);
`ifdef SLIDE_AVG_EN
    int q, d;
    q = 1 << AVG_SHFT;
    if (!exp_primed[exp_slot]) begin
      exp_pot[exp_slot] = v;
    end else begin
      d = v - exp_pot[exp_slot];
      exp_pot[exp_slot] += (d >= 0) ? d / q : -((-d + q - 1) / q);
    end
    exp_primed[exp_slot] = 1'b1;
`else
    exp_pot[exp_slot] = v;
`endif
  endtask

  task automatic model_advance();
    exp_slot = (exp_slot + 1) % NUM_CH;
  endtask

  // A2D responder: waits for strt_cnv, then raises cnv_cmplt with res = v
  // dly clocks later. A stalled conversion never completes.
  task automatic conv(input int dly, input int v, input bit stall,
                      output bit seen, output int gap, output logic [2:0] ch,
                      output logic [NUM_CH-1:0] u, output logic sd,
                      output logic [NUM_CH*RES_W-1:0] pv, output int tcyc);
    seen = 1'b0; gap = 0; tcyc = 0; ch = '0; u = '0; sd = 1'b0; pv = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      gap = i + 1;
      if (strt_cnv === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) return;
    ch = chnnl;
    cnv_cmplt = 1'b0;
    if (stall) begin
      for (int i = 0; i < TIMEOUT_CYC + 100; i++) begin
        @(negedge clk);
        tcyc = i + 1;
        if (timeout === 1'b1) break;
      end
    end else begin
      repeat (dly) @(negedge clk);
      cnv_cmplt = 1'b1;
      res = v[RES_W-1:0];
      @(negedge clk);
    end
    u = upd; sd = scan_done; pv = pot_vals;
  endtask

  task automatic test_reset();
    int n_strt;
    rst = 1'b1; en = 1'b0; cnv_cmplt = 1'b0; res = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (chnnl !== ch_of(0)) begin n_bad++; $display("FAIL reset_chnnl got %0h want %0h", chnnl, ch_of(0)); end
    n_cmp++; if (strt_cnv !== 1'b0) begin n_bad++; $display("FAIL reset_strt got %0b want 0", strt_cnv); end
    n_cmp++; if (pot_vals !== '0) begin n_bad++; $display("FAIL reset_pot got %0h want 0", pot_vals); end
    n_cmp++; if (upd !== '0) begin n_bad++; $display("FAIL reset_upd got %0h want 0", upd); end
    n_cmp++; if (scan_done !== 1'b0) begin n_bad++; $display("FAIL reset_scan_done got %0b want 0", scan_done); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout got %0b want 0", timeout); end
    rst = 1'b0;
    model_reset();
    n_strt = 0;
    repeat (10) begin
      @(negedge clk);
      if (strt_cnv === 1'b1) n_strt++;
    end
    n_cmp++; if (n_strt !== 0) begin n_bad++; $display("FAIL idle_no_strt got %0d want 0", n_strt); end
  endtask

  task automatic test_scan();
    bit seen; int gap, tcyc, n_sd, v; logic [2:0] ch; logic [NUM_CH-1:0] u; logic sd;
    logic [NUM_CH*RES_W-1:0] pv;
    n_sd = 0;
    en = 1'b1;
    for (int k = 0; k < 2 * NUM_CH; k++) begin
      v = 'h100 * (int'(ch_of(exp_slot)) + 1);
      conv(20, v, 1'b0, seen, gap, ch, u, sd, pv, tcyc);
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL scan_strt got none want strt_cnv"); break; end
      model_capture(v);
      n_cmp++; if (gap !== ((k == 0) ? 1 : SETTLE_CYC)) begin n_bad++; $display("FAIL scan_gap got %0d want %0d", gap, (k == 0) ? 1 : SETTLE_CYC); end
      n_cmp++; if (ch !== ch_of(exp_slot)) begin n_bad++; $display("FAIL scan_chnnl got %0d want %0d", ch, ch_of(exp_slot)); end
      n_cmp++; if (u !== NUM_CH'(1 << exp_slot)) begin n_bad++; $display("FAIL scan_upd got %0h want %0h", u, 1 << exp_slot); end
      n_cmp++; if (sd !== (exp_slot == NUM_CH - 1)) begin n_bad++; $display("FAIL scan_done got %0b want %0b", sd, exp_slot == NUM_CH - 1); end
      n_cmp++; if (pv !== exp_vec()) begin n_bad++; $display("FAIL scan_pot got %0h want %0h", pv, exp_vec()); end
      if (sd === 1'b1) n_sd++;
      model_advance();
    end
    n_cmp++; if (pot_vals[RES_W*5 +: RES_W] !== 12'h800) begin n_bad++; $display("FAIL scan_slot5 got %0h want 800", pot_vals[RES_W*5 +: RES_W]); end
    n_cmp++; if (n_sd !== 2) begin n_bad++; $display("FAIL scan_done_count got %0d want 2", n_sd); end
  endtask

  task automatic test_random();
    bit seen; int gap, tcyc, v; logic [2:0] ch; logic [NUM_CH-1:0] u; logic sd;
    logic [NUM_CH*RES_W-1:0] pv;
    for (int k = 0; k < 18; k++) begin
      v = int'($urandom_range(0, (1 << RES_W) - 1));
      conv(int'($urandom_range(2, 40)), v, 1'b0, seen, gap, ch, u, sd, pv, tcyc);
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL rand_strt got none want strt_cnv"); break; end
      model_capture(v);
      res = RES_W'($urandom);
      n_cmp++; if (gap !== SETTLE_CYC) begin n_bad++; $display("FAIL rand_gap got %0d want %0d", gap, SETTLE_CYC); end
      n_cmp++; if (ch !== ch_of(exp_slot)) begin n_bad++; $display("FAIL rand_chnnl got %0d want %0d", ch, ch_of(exp_slot)); end
      n_cmp++; if (u !== NUM_CH'(1 << exp_slot)) begin n_bad++; $display("FAIL rand_upd got %0h want %0h", u, 1 << exp_slot); end
      n_cmp++; if (sd !== (exp_slot == NUM_CH - 1)) begin n_bad++; $display("FAIL rand_done got %0b want %0b", sd, exp_slot == NUM_CH - 1); end
      n_cmp++; if (pv !== exp_vec()) begin n_bad++; $display("FAIL rand_pot got %0h want %0h", pv, exp_vec()); end
      model_advance();
    end
  endtask

  task automatic test_stale_cmplt();
    bit seen; int gap, tcyc, v; logic [2:0] ch; logic [NUM_CH-1:0] u; logic sd;
    logic [NUM_CH*RES_W-1:0] pv;
    v = int'($urandom_range(0, (1 << RES_W) - 1));
    conv(1, v, 1'b0, seen, gap, ch, u, sd, pv, tcyc);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL stale_strt got none want strt_cnv"); return; end
    n_cmp++; if (u !== '0) begin n_bad++; $display("FAIL stale_first_wait_upd got %0h want 0", u); end
    n_cmp++; if (pv !== exp_vec()) begin n_bad++; $display("FAIL stale_first_wait_pot got %0h want %0h", pv, exp_vec()); end
    @(negedge clk);
    model_capture(v);
    n_cmp++; if (upd !== NUM_CH'(1 << exp_slot)) begin n_bad++; $display("FAIL stale_upd got %0h want %0h", upd, 1 << exp_slot); end
    n_cmp++; if (pot_vals !== exp_vec()) begin n_bad++; $display("FAIL stale_pot got %0h want %0h", pot_vals, exp_vec()); end
    model_advance();
  endtask

  task automatic test_timeout();
    bit seen; int gap, tcyc, v; logic [2:0] ch; logic [NUM_CH-1:0] u; logic sd;
    logic [NUM_CH*RES_W-1:0] pv;
    for (int k = 0; k < NUM_CH && exp_slot != 2; k++) begin
      v = int'($urandom_range(0, (1 << RES_W) - 1));
      conv(20, v, 1'b0, seen, gap, ch, u, sd, pv, tcyc);
      model_capture(v);
      model_advance();
    end
    conv(0, 0, 1'b1, seen, gap, ch, u, sd, pv, tcyc);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL tmo_strt got none want strt_cnv"); return; end
    n_cmp++; if (ch !== ch_of(2)) begin n_bad++; $display("FAIL tmo_chnnl got %0d want %0d", ch, ch_of(2)); end
    n_cmp++; if (tcyc !== TIMEOUT_CYC + 1) begin n_bad++; $display("FAIL tmo_latency got %0d want %0d", tcyc, TIMEOUT_CYC + 1); end
    n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL tmo_flag got %0b want 1", timeout); end
    n_cmp++; if (u !== '0) begin n_bad++; $display("FAIL tmo_upd got %0h want 0", u); end
    n_cmp++; if (sd !== 1'b0) begin n_bad++; $display("FAIL tmo_done got %0b want 0", sd); end
    n_cmp++; if (pv !== exp_vec()) begin n_bad++; $display("FAIL tmo_pot got %0h want %0h", pv, exp_vec()); end
    model_advance();
    v = int'($urandom_range(0, (1 << RES_W) - 1));
    conv(20, v, 1'b0, seen, gap, ch, u, sd, pv, tcyc);
    model_capture(v);
    n_cmp++; if (ch !== ch_of(3)) begin n_bad++; $display("FAIL tmo_next_chnnl got %0d want %0d", ch, ch_of(3)); end
    n_cmp++; if (u !== NUM_CH'(1 << 3)) begin n_bad++; $display("FAIL tmo_next_upd got %0h want 8", u); end
    n_cmp++; if (pv !== exp_vec()) begin n_bad++; $display("FAIL tmo_next_pot got %0h want %0h", pv, exp_vec()); end
    n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky got %0b want 1", timeout); end
    model_advance();
  endtask

  task automatic test_en_drop();
    bit seen; int gap, tcyc, v, n_strt; logic [2:0] ch; logic [NUM_CH-1:0] u; logic sd;
    logic [NUM_CH*RES_W-1:0] pv;
    for (int k = 0; k < NUM_CH && exp_slot != 1; k++) begin
      v = int'($urandom_range(0, (1 << RES_W) - 1));
      conv(20, v, 1'b0, seen, gap, ch, u, sd, pv, tcyc);
      model_capture(v);
      model_advance();
    end
    en = 1'b0;
    for (int s = 1; s < NUM_CH; s++) begin
      v = int'($urandom_range(0, (1 << RES_W) - 1));
      conv(int'($urandom_range(2, 30)), v, 1'b0, seen, gap, ch, u, sd, pv, tcyc);
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL endrop_strt slot %0d got none want strt_cnv", s); break; end
      model_capture(v);
      n_cmp++; if (ch !== ch_of(s)) begin n_bad++; $display("FAIL endrop_chnnl got %0d want %0d", ch, ch_of(s)); end
      n_cmp++; if (pv !== exp_vec()) begin n_bad++; $display("FAIL endrop_pot got %0h want %0h", pv, exp_vec()); end
      model_advance();
    end
    n_strt = 0;
    repeat (100) begin
      @(negedge clk);
      if (strt_cnv === 1'b1) n_strt++;
    end
    n_cmp++; if (n_strt !== 0) begin n_bad++; $display("FAIL endrop_idle_strt got %0d want 0", n_strt); end
    en = 1'b1;
    v = int'($urandom_range(0, (1 << RES_W) - 1));
    conv(20, v, 1'b0, seen, gap, ch, u, sd, pv, tcyc);
    model_capture(v);
    n_cmp++; if (gap !== 1) begin n_bad++; $display("FAIL resume_gap got %0d want 1", gap); end
    n_cmp++; if (ch !== ch_of(0)) begin n_bad++; $display("FAIL resume_chnnl got %0d want %0d", ch, ch_of(0)); end
    n_cmp++; if (u !== NUM_CH'(1)) begin n_bad++; $display("FAIL resume_upd got %0h want 1", u); end
    model_advance();
  endtask

  task automatic test_rst_mid();
    bit seen; int gap, tcyc, v; logic [2:0] ch; logic [NUM_CH-1:0] u; logic sd;
    logic [NUM_CH*RES_W-1:0] pv;
    for (int k = 0; k < NUM_CH && exp_slot != 3; k++) begin
      v = int'($urandom_range(0, (1 << RES_W) - 1));
      conv(20, v, 1'b0, seen, gap, ch, u, sd, pv, tcyc);
      model_capture(v);
      model_advance();
    end
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (strt_cnv === 1'b1) begin seen = 1'b1; break; end
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rstmid_strt got none want strt_cnv"); end
    cnv_cmplt = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (chnnl !== ch_of(0)) begin n_bad++; $display("FAIL rstmid_chnnl got %0h want %0h", chnnl, ch_of(0)); end
    n_cmp++; if (strt_cnv !== 1'b0) begin n_bad++; $display("FAIL rstmid_strt_lvl got %0b want 0", strt_cnv); end
    n_cmp++; if (pot_vals !== '0) begin n_bad++; $display("FAIL rstmid_pot got %0h want 0", pot_vals); end
    n_cmp++; if (upd !== '0) begin n_bad++; $display("FAIL rstmid_upd got %0h want 0", upd); end
    n_cmp++; if (scan_done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got %0b want 0", scan_done); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL rstmid_timeout got %0b want 0", timeout); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      v = int'($urandom_range(0, (1 << RES_W) - 1));
      conv(int'($urandom_range(2, 30)), v, 1'b0, seen, gap, ch, u, sd, pv, tcyc);
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL restart_strt got none want strt_cnv"); break; end
      model_capture(v);
      if (k == 0) begin
        n_cmp++; if (gap !== 1) begin n_bad++; $display("FAIL restart_gap got %0d want 1", gap); end
      end
      n_cmp++; if (ch !== ch_of(exp_slot)) begin n_bad++; $display("FAIL restart_chnnl got %0d want %0d", ch, ch_of(exp_slot)); end
      n_cmp++; if (u !== NUM_CH'(1 << exp_slot)) begin n_bad++; $display("FAIL restart_upd got %0h want %0h", u, 1 << exp_slot); end
      n_cmp++; if (sd !== (exp_slot == NUM_CH - 1)) begin n_bad++; $display("FAIL restart_done got %0b want %0b", sd, exp_slot == NUM_CH - 1); end
      n_cmp++; if (pv !== exp_vec()) begin n_bad++; $display("FAIL restart_pot got %0h want %0h", pv, exp_vec()); end
      model_advance();
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_random();
    test_stale_cmplt();
    test_timeout();
    test_en_drop();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
